gated_bcd_counter: RTL and testbench
====================================

# gated_bcd_counter

Counting and display-hold stage directly downstream of the frequency-meter gate controller. Counts rising edges of the signal under test while the gate `enable` is high, zeroes on `clear`, and on each rising edge of `latch` copies the running count into a stable output register for the seven-segment display driver. Decimal digits are kept in BCD, and an overflow flag marks counts that exceeded the display range.

## Interface
Parameters:
- `DIGITS`, 4: number of BCD digits in the counter and the display register.
- `SYNC_STAGES`, 2: flip-flop depth of the input synchronizers; legal range 2–3.

Ports:
- `clk`  in  1  system clock; single clock domain for the whole block.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `sigIn`  in  1  signal under test; asynchronous to `clk`.
- `enable`  in  1  gate from the control stage; counting is allowed while high.
- `clear`  in  1  from the control stage; zeroes the running count while high.
- `latch`  in  1  from the control stage; a rising edge captures the running count.
- `testMode`  in  2  range select; captured with each latch and used only for the decimal-point output.
- `bcdOut`  out  4*DIGITS  latched count; digit 0 occupies bits [3:0] and is the least significant.
- `overflow`  out  1  latched overflow flag that travels with `bcdOut`.
- `dpSel`  out  2  latched copy of `testMode`, consumed by the display driver.
- `dataValid`  out  1  one-cycle pulse that marks a new capture.

## Operation
- **Synchronization.** `sigIn`, `enable`, `clear`, `latch` and `testMode` each pass through SYNC_STAGES flops. All five use equal depth so their relative alignment is preserved.
- **Edge detection.**
  - A rising edge of synchronized `sigIn` produces `cntPulse`, one cycle wide.
  - A rising edge of synchronized `latch` produces `latPulse`, one cycle wide.
- **Running count.** The count is DIGITS BCD digits plus a sticky `ovfRun` bit. Priority per cycle:
  1. `clear` high: all digits become 0 and `ovfRun` becomes 0. Any `cntPulse` in that cycle is dropped.
  2. Otherwise, `enable` high and `cntPulse`: BCD increment. A digit at 9 with carry-in becomes 0 and carries out.
  3. Otherwise: hold.
- **Saturation.** An increment when all digits are 9 leaves the count at all-9s and sets `ovfRun`. Once set, `ovfRun` stays set until `clear`.
- **Capture.** On `latPulse`:
  - `bcdOut`, `overflow` and `dpSel` load the running count, `ovfRun` and synchronized `testMode`.
  - If `cntPulse` and `latPulse` coincide while counting, the capture takes the pre-increment value. The increment still applies to the running count.
  - A capture is allowed whatever the state of `enable` or `clear`. If `clear` is also high, the capture takes the value before clearing.
- **`dataValid`.** High for exactly the cycle after `latPulse`.
- **Digit legality.** Digits never hold the codes 10–15.
- **Reset.**
  - All synchronizer flops are 0. Edge-detector history is 0, so no spurious pulse occurs on release.
  - Running count is 0 and `ovfRun` is 0.
  - `bcdOut` is 0, `overflow` is 0, `dpSel` is 0 and `dataValid` is 0.
  - Reset asserted mid-gate discards the partial count. Nothing is latched.

## Timing
- **Input requirements.** `sigIn` high and low phases must each be at least 2 `clk` periods. Faster signals are under-counted; this is not flagged.
- **Latency, `sigIn` to count.** A `sigIn` rise becomes a `cntPulse` SYNC_STAGES+1 cycles after the first sampling edge. The running count changes one cycle later.
- **Latency, `latch` to output.** A `latch` rise updates `bcdOut`, `overflow` and `dpSel` SYNC_STAGES+2 edges later. `dataValid` is high during that same cycle.
- **Holding.** `bcdOut` holds between captures independent of `enable`, `clear` and `sigIn`.
- **Gate alignment.** Control inputs go through the same synchronizer depth, so the gate window seen by the counter equals the controller's `enable` high time to within ±1 cycle.
- **Concurrency.** Back-to-back `latch` rises spaced at least 2 cycles apart each produce a capture and a `dataValid` pulse.

## Structure
- **Shared package** holds:
  - the BCD digit type (4 bits);
  - constant `BCD_MAX` = 9;
  - the `testMode` encoding constants shared with the gate controller and the display driver.
- **Sub-module `bcd_digit`**: one digit with inputs `inc`, `clr` and `carryIn`, and outputs `digit` and `carryOut`. It is instantiated DIGITS times in a generate loop.
  - `carryOut` asserts when `digit` is 9 and `carryIn` is high.
  - The top level gates the final carry into saturation logic and `ovfRun`.
- **Top level** holds the synchronizers, edge detectors, capture registers and `dataValid`.

## Test plan
- **Basic count.** Reset, then `clear` high for 4 cycles, then `enable` high, 37 `sigIn` pulses of period 6, `enable` low, then a `latch` rise. Required: `bcdOut` = 0x0037, `overflow` = 0, `dataValid` a single pulse SYNC_STAGES+2 edges after the `latch` rise.
- **Gate closed.** `enable` low with 20 `sigIn` pulses, then latch. Required: `bcdOut` = 0x0000.
- **Carry chain.** Count 999 then 1 more pulse. Required: `bcdOut` = 0x1000. No digit above 9 at any cycle; checked by an assertion on all digits.
- **Saturation.** 10001 pulses with DIGITS = 4. Required: `bcdOut` = 0x9999, `overflow` = 1. Then `clear` and latch: `bcdOut` = 0x0000, `overflow` = 0.
- **Coincidence.** At a count of 0x0041, `cntPulse` and `latPulse` in the same cycle. Required: `bcdOut` = 0x0041 and the running count = 42. A further latch gives 0x0042. Latch with `clear` high at a count of 0x0050: required `bcdOut` = 0x0050.
- **Reset mid-gate.** Reset asserted after 15 pulses, then released. Required: all outputs 0 immediately, no `dataValid` on release. A new gate of 3 pulses latches 0x0003. `dpSel` equals the `testMode` value applied before the latch.

Source files
------------

// File: rtl/gated_bcd_counter_pkg.sv
// Shared types and constants for the frequency-meter counting stage.
// The gate controller and the display driver use the same testMode encoding.
package gated_bcd_counter_pkg;

   typedef logic [3:0] bcdDigit_t;
   typedef logic [1:0] testMode_t;

   localparam bcdDigit_t BCD_MAX = 4'd9;

   // Gate-time ranges; the display driver places the decimal point from these
   localparam testMode_t TM_GATE_1S    = 2'd0;
   localparam testMode_t TM_GATE_100MS = 2'd1;
   localparam testMode_t TM_GATE_10MS  = 2'd2;
   localparam testMode_t TM_GATE_1MS   = 2'd3;

   function automatic logic isLegalDigit(input bcdDigit_t d);
      return d <= BCD_MAX;
   endfunction

endpackage

// File: rtl/gated_bcd_counter_if.sv
// Control inputs and display-side outputs of the counting stage.
// The master side is the gate controller plus display driver; the slave is the counter.
interface gated_bcd_counter_if #(
   parameter int unsigned DIGITS = 4
);
   import gated_bcd_counter_pkg::*;

   logic                sigIn;
   logic                enable;
   logic                clear;
   logic                latch;
   testMode_t           testMode;
   logic [4*DIGITS-1:0] bcdOut;
   logic                overflow;
   testMode_t           dpSel;
   logic                dataValid;

   modport master (
      output sigIn, enable, clear, latch, testMode,
      input  bcdOut, overflow, dpSel, dataValid
   );

   modport slave (
      input  sigIn, enable, clear, latch, testMode,
      output bcdOut, overflow, dpSel, dataValid
   );

endinterface

// File: rtl/gated_bcd_counter_bcd_digit.sv
// One BCD digit of the running count: increments on inc with carry-in, wraps 9 -> 0.
module bcd_digit
   import gated_bcd_counter_pkg::*;
(
   input  logic      clk,
   input  logic      rst_n,
   input  logic      inc,
   input  logic      clr,
   input  logic      carryIn,
   output bcdDigit_t digit,
   output logic      carryOut
);

   assign carryOut = carryIn && (digit == BCD_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digit <= '0;
      end else if (clr) begin
         digit <= '0;
      end else if (inc && carryIn) begin
         digit <= (digit == BCD_MAX) ? '0 : digit + 4'd1;
      end
   end

endmodule

// File: rtl/gated_bcd_counter.sv
// Gated BCD event counter with synchronizers, edge detection, saturation and
// a display-hold capture register loaded on each latch rise.
module gated_bcd_counter
   import gated_bcd_counter_pkg::*;
#(
   parameter int unsigned DIGITS      = 4,
   parameter int unsigned SYNC_STAGES = 2
) (
   input logic clk,
   input logic rst_n,
   gated_bcd_counter_if.slave bus
);

   localparam int unsigned SW = 6;

   logic [SYNC_STAGES-1:0][SW-1:0] syncReg;
   logic [SW-1:0]                  syncIn;
   logic [SW-1:0]                  syncOut;

   logic      sigPrev, latPrev;
   logic      cntPulse, latPulse;
   logic      enAl, clrAl;
   testMode_t tmAl;

   logic [4*DIGITS-1:0] runCount;
   logic                ovfRun;
   logic                allNines;
   logic                incEn;

   assign syncIn  = {bus.testMode, bus.latch, bus.clear, bus.enable, bus.sigIn};
   assign syncOut = syncReg[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         syncReg <= '0;
      end else begin
         syncReg[0] <= syncIn;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            syncReg[i] <= syncReg[i-1];
         end
      end
   end

   // Controls get one extra register so they stay aligned with the registered pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sigPrev  <= 1'b0;
         latPrev  <= 1'b0;
         cntPulse <= 1'b0;
         latPulse <= 1'b0;
         enAl     <= 1'b0;
         clrAl    <= 1'b0;
         tmAl     <= '0;
      end else begin
         sigPrev  <= syncOut[0];
         latPrev  <= syncOut[3];
         cntPulse <= syncOut[0] & ~sigPrev;
         latPulse <= syncOut[3] & ~latPrev;
         enAl     <= syncOut[1];
         clrAl    <= syncOut[2];
         tmAl     <= syncOut[5:4];
      end
   end

   assign incEn = enAl && cntPulse && !allNines;

   for (genvar g = 0; g < DIGITS; g++) begin : gDigit
      logic cin;
      logic cout;
      if (g == 0) begin : gFirst
         assign cin = 1'b1;
      end else begin : gRest
         assign cin = gDigit[g-1].cout;
      end
      bcd_digit uDigit (
         .clk      (clk),
         .rst_n    (rst_n),
         .inc      (incEn),
         .clr      (clrAl),
         .carryIn  (cin),
         .digit    (runCount[4*g +: 4]),
         .carryOut (cout)
      );
   end

   // Carry out of the top digit with carry-in forced high means every digit is 9
   assign allNines = gDigit[DIGITS-1].cout;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovfRun <= 1'b0;
      end else if (clrAl) begin
         ovfRun <= 1'b0;
      end else if (enAl && cntPulse && allNines) begin
         ovfRun <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.bcdOut    <= '0;
         bus.overflow  <= 1'b0;
         bus.dpSel     <= '0;
         bus.dataValid <= 1'b0;
      end else begin
         bus.dataValid <= latPulse;
         if (latPulse) begin
            bus.bcdOut   <= runCount;
            bus.overflow <= ovfRun;
            bus.dpSel    <= tmAl;
         end
      end
   end

endmodule

// File: tb/tb_gated_bcd_counter.sv
// Directed bench for gated_bcd_counter: counting, gating, carry, saturation,
// capture coincidence and reset behaviour against hand-computed values.
module tb_gated_bcd_counter;
   import gated_bcd_counter_pkg::*;

   localparam int DIG  = 4;
   localparam int SYNC = 2;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   int   digitErr;

   gated_bcd_counter_if #(.DIGITS(DIG)) bus ();

   gated_bcd_counter #(.DIGITS(DIG), .SYNC_STAGES(SYNC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watch every digit of the running count and the display register
   always @(negedge clk) begin
      if (rst_n) begin
         for (int d = 0; d < DIG; d++) begin
            if (!isLegalDigit(dut.runCount[4*d +: 4]) || !isLegalDigit(bus.bcdOut[4*d +: 4]))
               digitErr++;
         end
      end
   end

   task automatic pulses(input int n, input int hi, input int lo);
      for (int k = 0; k < n; k++) begin
         bus.sigIn = 1'b1;
         repeat (hi) @(negedge clk);
         bus.sigIn = 1'b0;
         repeat (lo) @(negedge clk);
      end
      repeat (6) @(negedge clk);
   endtask

   task automatic doLatch();
      bus.latch = 1'b1;
      repeat (3) @(negedge clk);
      bus.latch = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic doClear();
      bus.clear = 1'b1;
      repeat (4) @(negedge clk);
      bus.clear = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.sigIn = 0; bus.enable = 0; bus.clear = 0; bus.latch = 0; bus.testMode = TM_GATE_1S;
      repeat (3) @(negedge clk);
      total++;
      if (bus.bcdOut !== 16'h0000 || bus.overflow !== 1'b0 || bus.dpSel !== 2'd0 || bus.dataValid !== 1'b0) begin
         bad++;
         $display("FAIL reset_outputs: got bcd=%h ovf=%b dp=%0d dv=%b, want 0000 0 0 0",
                  bus.bcdOut, bus.overflow, bus.dpSel, bus.dataValid);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_basic_count();
      int dvHits;
      doClear();
      bus.enable = 1'b1;
      repeat (3) @(negedge clk);
      pulses(37, 3, 3);
      bus.enable = 1'b0;
      repeat (4) @(negedge clk);
      dvHits = 0;
      bus.latch = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         @(posedge clk);
         #1;
         total++;
         if (bus.dataValid !== (i == SYNC + 2)) begin
            bad++;
            $display("FAIL basic_dv_edge%0d: got dv=%b, want %b", i, bus.dataValid, (i == SYNC + 2));
         end
      end
      @(negedge clk);
      bus.latch = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if (bus.bcdOut !== 16'h0037 || bus.overflow !== 1'b0) begin
         bad++;
         $display("FAIL basic_count: got bcd=%h ovf=%b, want 0037 0", bus.bcdOut, bus.overflow);
      end
   endtask

   task automatic test_gate_closed();
      doClear();
      pulses(20, 3, 3);
      doLatch();
      total++;
      if (bus.bcdOut !== 16'h0000) begin
         bad++;
         $display("FAIL gate_closed: got bcd=%h, want 0000", bus.bcdOut);
      end
   endtask

   task automatic test_carry_chain();
      doClear();
      bus.enable = 1'b1;
      repeat (3) @(negedge clk);
      pulses(999, 2, 2);
      doLatch();
      total++;
      if (bus.bcdOut !== 16'h0999) begin
         bad++;
         $display("FAIL carry_999: got bcd=%h, want 0999", bus.bcdOut);
      end
      pulses(1, 2, 2);
      doLatch();
      total++;
      if (bus.bcdOut !== 16'h1000 || bus.overflow !== 1'b0) begin
         bad++;
         $display("FAIL carry_1000: got bcd=%h ovf=%b, want 1000 0", bus.bcdOut, bus.overflow);
      end
      bus.enable = 1'b0;
   endtask

   task automatic test_saturation();
      doClear();
      bus.enable = 1'b1;
      repeat (3) @(negedge clk);
      pulses(9999, 2, 2);
      doLatch();
      total++;
      if (bus.bcdOut !== 16'h9999 || bus.overflow !== 1'b0) begin
         bad++;
         $display("FAIL sat_9999: got bcd=%h ovf=%b, want 9999 0", bus.bcdOut, bus.overflow);
      end
      pulses(2, 2, 2);
      doLatch();
      total++;
      if (bus.bcdOut !== 16'h9999 || bus.overflow !== 1'b1) begin
         bad++;
         $display("FAIL sat_10001: got bcd=%h ovf=%b, want 9999 1", bus.bcdOut, bus.overflow);
      end
      bus.enable = 1'b0;
      repeat (4) @(negedge clk);
      doClear();
      doLatch();
      total++;
      if (bus.bcdOut !== 16'h0000 || bus.overflow !== 1'b0) begin
         bad++;
         $display("FAIL sat_cleared: got bcd=%h ovf=%b, want 0000 0", bus.bcdOut, bus.overflow);
      end
   endtask

   task automatic test_coincidence();
      doClear();
      bus.testMode = TM_GATE_1MS;
      bus.enable = 1'b1;
      repeat (3) @(negedge clk);
      pulses(41, 3, 3);
      bus.sigIn = 1'b1;
      bus.latch = 1'b1;
      repeat (3) @(negedge clk);
      bus.sigIn = 1'b0;
      bus.latch = 1'b0;
      repeat (5) @(negedge clk);
      total++;
      if (bus.bcdOut !== 16'h0041 || bus.dpSel !== TM_GATE_1MS) begin
         bad++;
         $display("FAIL coinc_pre: got bcd=%h dp=%0d, want 0041 3", bus.bcdOut, bus.dpSel);
      end
      total++;
      if (dut.runCount !== 16'h0042) begin
         bad++;
         $display("FAIL coinc_run: got run=%h, want 0042", dut.runCount);
      end
      doLatch();
      total++;
      if (bus.bcdOut !== 16'h0042) begin
         bad++;
         $display("FAIL coinc_next: got bcd=%h, want 0042", bus.bcdOut);
      end
      pulses(8, 3, 3);
      bus.clear = 1'b1;
      bus.latch = 1'b1;
      repeat (3) @(negedge clk);
      bus.clear = 1'b0;
      bus.latch = 1'b0;
      repeat (5) @(negedge clk);
      total++;
      if (bus.bcdOut !== 16'h0050 || dut.runCount !== 16'h0000) begin
         bad++;
         $display("FAIL latch_with_clear: got bcd=%h run=%h, want 0050 0000", bus.bcdOut, dut.runCount);
      end
   endtask

   task automatic test_reset_mid_gate();
      pulses(15, 3, 3);
      rst_n = 1'b0;
      #1;
      total++;
      if (bus.bcdOut !== 16'h0000 || bus.overflow !== 1'b0 || bus.dpSel !== 2'd0 || bus.dataValid !== 1'b0) begin
         bad++;
         $display("FAIL midgate_reset: got bcd=%h ovf=%b dp=%0d dv=%b, want 0000 0 0 0",
                  bus.bcdOut, bus.overflow, bus.dpSel, bus.dataValid);
      end
      bus.enable = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         total++;
         if (bus.dataValid !== 1'b0) begin
            bad++;
            $display("FAIL release_dv%0d: got dv=%b, want 0", i, bus.dataValid);
         end
      end
      bus.testMode = TM_GATE_10MS;
      bus.enable = 1'b1;
      repeat (3) @(negedge clk);
      pulses(3, 3, 3);
      bus.enable = 1'b0;
      repeat (4) @(negedge clk);
      doLatch();
      total++;
      if (bus.bcdOut !== 16'h0003 || bus.dpSel !== TM_GATE_10MS || bus.overflow !== 1'b0) begin
         bad++;
         $display("FAIL regate: got bcd=%h dp=%0d ovf=%b, want 0003 2 0", bus.bcdOut, bus.dpSel, bus.overflow);
      end
   endtask

   task automatic test_back_to_back();
      int dvCount;
      dvCount = 0;
      for (int r = 0; r < 3; r++) begin
         bus.latch = 1'b1;
         repeat (2) @(negedge clk);
         if (bus.dataValid === 1'b1) dvCount++;
         bus.latch = 1'b0;
         repeat (2) @(negedge clk);
         if (bus.dataValid === 1'b1) dvCount++;
      end
      repeat (4) @(negedge clk);
      if (bus.dataValid === 1'b1) dvCount++;
      total++;
      if (dvCount !== 3) begin
         bad++;
         $display("FAIL back_to_back: got %0d dataValid pulses, want 3", dvCount);
      end
   endtask

   task automatic test_digit_legality();
      total++;
      if (digitErr !== 0) begin
         bad++;
         $display("FAIL digit_legal: got %0d illegal digit samples, want 0", digitErr);
      end
   endtask

   initial begin
      total = 0;
      bad = 0;
      digitErr = 0;
      test_reset();
      test_basic_count();
      test_gate_closed();
      test_carry_chain();
      test_saturation();
      test_coincidence();
      test_reset_mid_gate();
      test_back_to_back();
      test_digit_legality();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
